// File: rtl/cpc_bus_pkg.sv
// rtl/cpc_bus_pkg.sv - shared constants and types for the CPC bus cycle tracker
//
// Purpose : cyc_type encodings (CPU_BUS_*), FSM state encoding, control
//           vector bit positions and the register-select data mask.
// Ports   : none (package)

package cpc_bus_pkg;

  // cyc_type output encodings
  localparam logic [2:0] CPU_BUS_IDLE   = 3'd0;
  localparam logic [2:0] CPU_BUS_MEM_RD = 3'd1;
  localparam logic [2:0] CPU_BUS_MEM_WR = 3'd2;
  localparam logic [2:0] CPU_BUS_IO_RD  = 3'd3;
  localparam logic [2:0] CPU_BUS_IO_WR  = 3'd4;
  localparam logic [2:0] CPU_BUS_RFSH   = 3'd5;
  localparam logic [2:0] CPU_BUS_INTACK = 3'd6;

  // data[7:6] value that selects the bank register on an IO write
  localparam logic [1:0] REGSEL_MASK = 2'b11;

  // Bit positions inside the 6-bit control strobe vector
  localparam int CTL_MREQ = 5;
  localparam int CTL_IORQ = 4;
  localparam int CTL_RD   = 3;
  localparam int CTL_WR   = 2;
  localparam int CTL_M1   = 1;
  localparam int CTL_RFSH = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MEM_PEND,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_IO_PEND,
    ST_IO_RD,
    ST_IO_WR,
    ST_RFSH,
    ST_INTACK,
    ST_DONE
  } bus_state_t;

  // Reported cycle type for a state; pending and done states report IDLE
  function automatic logic [2:0] state_cyc_type(input bus_state_t st);
    logic [2:0] t;
    t = CPU_BUS_IDLE;
    case (st)
      ST_MEM_RD: t = CPU_BUS_MEM_RD;
      ST_MEM_WR: t = CPU_BUS_MEM_WR;
      ST_IO_RD:  t = CPU_BUS_IO_RD;
      ST_IO_WR:  t = CPU_BUS_IO_WR;
      ST_RFSH:   t = CPU_BUS_RFSH;
      ST_INTACK: t = CPU_BUS_INTACK;
      default:   t = CPU_BUS_IDLE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cpc_ctrl_sync.sv
// rtl/cpc_ctrl_sync.sv - input sampling and optional deglitch of the Z80 strobes
//
// Purpose : registers the control strobe vector and the data/address side bus.
//           CTRL_DEGLITCH_EN defined: two sampling flops per strobe and a per-bit
//           agree filter (output follows only when the last two samples match);
//           side bus delayed by two flops to stay aligned with the filtered strobes.
//           CTRL_DEGLITCH_EN undefined: one sampling flop, no filtering.
// Ports   : clk, reset (sync, active-high)
//           ctrl_in[5:0] raw strobes {mreq,iorq,rd,wr,m1,rfsh}_b -> ctrl_s[5:0]
//           side_in[9:0] raw {adr15, adr8, data[7:0]}            -> side_s[9:0]

module cpc_ctrl_sync
  import cpc_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] ctrl_in,
  input  logic [9:0] side_in,
  output logic [5:0] ctrl_s,
  output logic [9:0] side_s
);

  // Strobe flops reset to "asserted" (0) so the tracker can never arm on
  // reset values; it has to see real high samples first.
`ifdef CTRL_DEGLITCH_EN
  logic [5:0] st1, st2, held, agree;
  logic [9:0] side1, side2;

  assign agree  = ~(st1 ^ st2);
  assign ctrl_s = (agree & st2) | (~agree & held);
  assign side_s = side2;

  always_ff @(posedge clk) begin
    if (reset) begin
      st1   <= '0;
      st2   <= '0;
      held  <= '0;
      side1 <= '0;
      side2 <= '0;
    end else begin
      st1   <= ctrl_in;
      st2   <= st1;
      held  <= ctrl_s;
      side1 <= side_in;
      side2 <= side1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_s <= '0;
      side_s <= '0;
    end else begin
      ctrl_s <= ctrl_in;
      side_s <= side_in;
    end
  end
`endif

endmodule

// File: rtl/cpc_bus_cycle_tracker.sv
// rtl/cpc_bus_cycle_tracker.sv - Z80 bus cycle classifier for the RAM expansion
//
// Purpose : classifies sampled Z80 strobes into bus cycles, raises clean
//           per-cycle flags, emits a one-cycle bank register write strobe and
//           aborts cycles that stay active for TMO_CYCLES clocks.
//           Optional macro CTRL_DEGLITCH_EN (in cpc_ctrl_sync) adds a 2-flop
//           agree filter on the strobes (+1 clk latency).
// Params  : TMO_CYCLES (4..255) active clocks before abort, CW counter width
// Ports   : clk, reset (sync, active-high)
//           mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b  raw Z80 strobes
//           adr15, adr8, data[7:0]                    raw address/data
//           cyc_type[2:0]  current cycle class (CPU_BUS_*)
//           mwr_cyc, mrd_cyc  memory write / read active
//           regwr_stb, regwr_data[5:0], regwr_adr8  bank register write
//           tmo_stb  cycle aborted by timeout

module cpc_bus_cycle_tracker
  import cpc_bus_pkg::*;
#(
  parameter int TMO_CYCLES = 16,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mreq_b,
  input  logic       iorq_b,
  input  logic       rd_b,
  input  logic       wr_b,
  input  logic       m1_b,
  input  logic       rfsh_b,
  input  logic       adr15,
  input  logic       adr8,
  input  logic [7:0] data,
  output logic [2:0] cyc_type,
  output logic       mwr_cyc,
  output logic       mrd_cyc,
  output logic       regwr_stb,
  output logic [5:0] regwr_data,
  output logic       regwr_adr8,
  output logic       tmo_stb
);

  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

  logic [5:0] ctrl_s;
  logic [9:0] side_s;

  cpc_ctrl_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .ctrl_in ({mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b}),
    .side_in ({adr15, adr8, data}),
    .ctrl_s  (ctrl_s),
    .side_s  (side_s)
  );

  logic       s_mreq_b, s_iorq_b, s_rd_b, s_wr_b, s_m1_b, s_rfsh_b;
  logic       s_adr15, s_adr8;
  logic [7:0] s_data;

  assign s_mreq_b = ctrl_s[CTL_MREQ];
  assign s_iorq_b = ctrl_s[CTL_IORQ];
  assign s_rd_b   = ctrl_s[CTL_RD];
  assign s_wr_b   = ctrl_s[CTL_WR];
  assign s_m1_b   = ctrl_s[CTL_M1];
  assign s_rfsh_b = ctrl_s[CTL_RFSH];
  assign s_adr15  = side_s[9];
  assign s_adr8   = side_s[8];
  assign s_data   = side_s[7:0];

  bus_state_t    state, nxt;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          tmo_hit;
  logic          regsel;
  logic          io_wr_entry;
  logic          tmo_now;

  assign tmo_now = (cnt == TMO_LAST);
  assign regsel  = !s_adr15 && (s_data[7:6] == REGSEL_MASK);

  always_comb begin
    nxt     = state;
    tmo_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        // An unarmed tracker ignores strobes until both mreq and iorq have
        // been seen inactive (after reset or after a timeout abort).
        // Strobes already qualified by rd/wr skip the pending state.
        if (armed) begin
          if (!s_mreq_b) begin
            if (!s_rfsh_b)    nxt = ST_RFSH;
            else if (!s_wr_b) nxt = ST_MEM_WR;
            else if (!s_rd_b) nxt = ST_MEM_RD;
            else              nxt = ST_MEM_PEND;
          end else if (!s_iorq_b) begin
            if (!s_m1_b)      nxt = ST_INTACK;
            else if (!s_wr_b) nxt = ST_IO_WR;
            else if (!s_rd_b) nxt = ST_IO_RD;
            else              nxt = ST_IO_PEND;
          end
        end
      end
      ST_MEM_PEND: begin
        if (s_mreq_b)     nxt = ST_DONE;
        else if (tmo_now) begin
          nxt     = ST_DONE;
          tmo_hit = 1'b1;
        end
        else if (!s_wr_b) nxt = ST_MEM_WR;
        else if (!s_rd_b) nxt = ST_MEM_RD;
      end
      ST_IO_PEND: begin
        if (s_iorq_b)     nxt = ST_DONE;
        else if (tmo_now) begin
          nxt     = ST_DONE;
          tmo_hit = 1'b1;
        end
        else if (!s_wr_b) nxt = ST_IO_WR;
        else if (!s_rd_b) nxt = ST_IO_RD;
      end
      ST_MEM_RD, ST_MEM_WR, ST_RFSH: begin
        // Release is checked before timeout so it wins a same-clock tie
        if (s_mreq_b) nxt = ST_DONE;
        else if (tmo_now) begin
          nxt     = ST_DONE;
          tmo_hit = 1'b1;
        end
      end
      ST_IO_RD, ST_IO_WR, ST_INTACK: begin
        if (s_iorq_b) nxt = ST_DONE;
        else if (tmo_now) begin
          nxt     = ST_DONE;
          tmo_hit = 1'b1;
        end
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Only the transition into IO_WR qualifies, so a held wr_b strobes once
  assign io_wr_entry = (nxt == ST_IO_WR) && (state != ST_IO_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      armed      <= 1'b0;
      cyc_type   <= CPU_BUS_IDLE;
      mwr_cyc    <= 1'b0;
      mrd_cyc    <= 1'b0;
      regwr_stb  <= 1'b0;
      regwr_data <= '0;
      regwr_adr8 <= 1'b0;
      tmo_stb    <= 1'b0;
    end else begin
      state    <= nxt;
      cyc_type <= state_cyc_type(nxt);
      mwr_cyc  <= (nxt == ST_MEM_WR);
      mrd_cyc  <= (nxt == ST_MEM_RD);
      tmo_stb  <= tmo_hit;

      regwr_stb <= io_wr_entry && regsel;
      if (io_wr_entry && regsel) begin
        regwr_data <= s_data[5:0];
        regwr_adr8 <= s_adr8;
      end

      if (state == ST_IDLE)
        cnt <= '0;
      else if (state != ST_DONE && cnt != '1)
        cnt <= cnt + 1'b1;

      // A timed-out cycle is still on the bus; disarm so it is not re-reported
      if (tmo_hit)
        armed <= 1'b0;
      else if (state == ST_IDLE && s_mreq_b && s_iorq_b)
        armed <= 1'b1;
    end
  end

endmodule
